// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the IF-stage branch predictor: branch-type encodings
// (shared with the decode/EX logic) and the 2-bit counter states.
package branch_predictor_pkg;

  typedef logic [2:0] br_type_t;
  typedef logic [1:0] ctr_t;

  localparam br_type_t BR_NONE = 3'd0;
  localparam br_type_t BR_BEQ  = 3'd1;
  localparam br_type_t BR_BNE  = 3'd2;
  localparam br_type_t BR_BLT  = 3'd3;
  localparam br_type_t BR_BGE  = 3'd4;
  localparam br_type_t BR_BLTU = 3'd5;
  localparam br_type_t BR_BGEU = 3'd6;

  localparam ctr_t CTR_SNT = 2'd0;
  localparam ctr_t CTR_WNT = 2'd1;
  localparam ctr_t CTR_WT  = 2'd2;
  localparam ctr_t CTR_ST  = 2'd3;

endpackage

// File: rtl/branch_predictor_if.sv
// Pipeline <-> branch predictor bundle: IF lookup, EX resolution/training and
// the mispredict redirect. The pipeline is the master, the predictor the slave.
interface branch_predictor_if;
  import branch_predictor_pkg::*;

  logic [31:0] PCF;
  logic        PredTakenF;
  logic [31:0] PredTargetF;
  logic [31:0] PCE;
  br_type_t    BranchTypeE;
  logic        BranchE;
  logic [31:0] BrTargetE;
  logic        PredTakenE;
  logic [31:0] PredTargetE;
  logic        StallE;
  logic        MispredE;
  logic [31:0] CorrectPCE;
  logic [31:0] BrCnt;
  logic [31:0] MispCnt;

  modport master (
    output PCF, PCE, BranchTypeE, BranchE, BrTargetE, PredTakenE, PredTargetE, StallE,
    input  PredTakenF, PredTargetF, MispredE, CorrectPCE, BrCnt, MispCnt
  );

  modport slave (
    input  PCF, PCE, BranchTypeE, BranchE, BrTargetE, PredTakenE, PredTargetE, StallE,
    output PredTakenF, PredTargetF, MispredE, CorrectPCE, BrCnt, MispCnt
  );

endinterface

// File: rtl/branch_predictor_sat_ctr.sv
// 2-bit saturating counter next-state function (purely combinational).
module bp_sat_ctr
  import branch_predictor_pkg::*;
(
  input  ctr_t ctr,
  input  logic taken,
  output ctr_t ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (taken) begin
      if (ctr != CTR_ST) ctr_next = ctr + 2'd1;
    end else begin
      if (ctr != CTR_SNT) ctr_next = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with a 2-bit BHT per entry. IF does a combinational lookup
// on PCF; EX trains the entry selected by PCE and flags mispredicts.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ENTRIES = 64
) (
  input logic               clk,
  input logic               rst_n,
  branch_predictor_if.slave bus
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  ctr_t             ctr_q    [ENTRIES];

  logic [IDX_W-1:0] idx_f, idx_e;
  logic [TAG_W-1:0] tag_f, tag_e;
  logic             hit_f, hit_e, upd_e, mispred_e;
  ctr_t             ctr_next;
  logic [31:0]      br_cnt_q, misp_cnt_q;

  // PCF[1:0] carries no information for word-aligned instructions.
  logic unused_pcf_bits;
  assign unused_pcf_bits = ^bus.PCF[1:0];

  assign idx_f = bus.PCF[IDX_W+1:2];
  assign tag_f = bus.PCF[31:IDX_W+2];
  assign idx_e = bus.PCE[IDX_W+1:2];
  assign tag_e = bus.PCE[31:IDX_W+2];

  // IF lookup reads the registered table only, so a same-cycle EX write is not bypassed.
  assign hit_f           = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
  assign bus.PredTakenF  = rst_n && hit_f && ctr_q[idx_f][1];
  assign bus.PredTargetF = bus.PredTakenF ? target_q[idx_f] : 32'd0;

  assign hit_e     = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
  assign upd_e     = (bus.BranchTypeE != BR_NONE) && !bus.StallE && rst_n;
  assign mispred_e = upd_e && ((bus.BranchE != bus.PredTakenE) ||
                               (bus.BranchE && (bus.PredTargetE != bus.BrTargetE)));

  assign bus.MispredE   = mispred_e;
  assign bus.CorrectPCE = bus.BranchE ? bus.BrTargetE : (bus.PCE + 32'd4);
  assign bus.BrCnt      = br_cnt_q;
  assign bus.MispCnt    = misp_cnt_q;

  bp_sat_ctr u_sat_ctr (
    .ctr      (ctr_q[idx_e]),
    .taken    (bus.BranchE),
    .ctr_next (ctr_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= 32'd0;
        ctr_q[i]    <= CTR_WNT;
      end
    end else if (upd_e) begin
      if (hit_e) begin
        ctr_q[idx_e] <= ctr_next;
        if (bus.BranchE) target_q[idx_e] <= bus.BrTargetE;
      end else if (bus.BranchE) begin
        // Miss on a taken branch allocates, evicting any alias on this index.
        valid_q[idx_e]  <= 1'b1;
        tag_q[idx_e]    <= tag_e;
        target_q[idx_e] <= bus.BrTargetE;
        ctr_q[idx_e]    <= CTR_WT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      br_cnt_q   <= 32'd0;
      misp_cnt_q <= 32'd0;
    end else if (upd_e) begin
      br_cnt_q <= br_cnt_q + 32'd1;
      if (mispred_e) misp_cnt_q <= misp_cnt_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: training, saturation, aliasing, stall
// suppression and reset abort, with hand-computed expected values.
module tb_branch_predictor;
  import branch_predictor_pkg::*;

  logic clk;
  logic rst_n;

  int n_checks;
  int n_fail;
  logic [31:0] exp_br;
  logic [31:0] exp_misp;

  branch_predictor_if bus ();

  branch_predictor #(.ENTRIES(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive_idle();
    bus.PCE         = 32'd0;
    bus.BranchTypeE = BR_NONE;
    bus.BranchE     = 1'b0;
    bus.BrTargetE   = 32'd0;
    bus.PredTakenE  = 1'b0;
    bus.PredTargetE = 32'd0;
    bus.StallE      = 1'b0;
  endtask

  task automatic lookup(input string tag, input logic [31:0] pc, input logic exp_taken,
                        input logic [31:0] exp_tgt);
    bus.PCF = pc;
    #1;
    check({tag, "_taken"},  {31'd0, bus.PredTakenF}, {31'd0, exp_taken});
    check({tag, "_target"}, bus.PredTargetF, exp_tgt);
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_brcnt"},   bus.BrCnt,   exp_br);
    check({tag, "_mispcnt"}, bus.MispCnt, exp_misp);
  endtask

  // One resolved branch in EX. The same-cycle IF lookup of pc must equal the
  // carried prediction (pre-update contents). Returns at the following idle negedge.
  task automatic resolve(input string tag, input logic [31:0] pc, input br_type_t bt,
                         input logic taken, input logic [31:0] tgt, input logic pt,
                         input logic [31:0] ptgt, input logic exp_mp,
                         input logic [31:0] exp_cpc);
    @(negedge clk);
    bus.PCE         = pc;
    bus.BranchTypeE = bt;
    bus.BranchE     = taken;
    bus.BrTargetE   = tgt;
    bus.PredTakenE  = pt;
    bus.PredTargetE = ptgt;
    bus.StallE      = 1'b0;
    lookup({tag, "_pre"}, pc, pt, ptgt);
    check({tag, "_mispred"}, {31'd0, bus.MispredE}, {31'd0, exp_mp});
    check({tag, "_cpc"}, bus.CorrectPCE, exp_cpc);
    exp_br = exp_br + 32'd1;
    if (exp_mp) exp_misp = exp_misp + 32'd1;
    @(negedge clk);
    drive_idle();
    #1;
    check_counters(tag);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_br   = 32'd0;
    exp_misp = 32'd0;
    rst_n    = 1'b0;
    bus.PCF  = 32'h100;
    drive_idle();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // 1: reset state
    #1;
    lookup("rst", 32'h100, 1'b0, 32'd0);
    check_counters("rst");
    check("rst_mispred", {31'd0, bus.MispredE}, 32'd0);

    // 2: first taken BEQ allocates at WT
    resolve("alloc", 32'h100, BR_BEQ, 1'b1, 32'h140, 1'b0, 32'd0, 1'b1, 32'h140);
    lookup("alloc_post", 32'h100, 1'b1, 32'h140);

    // 3: WT->WNT->SNT, then four taken saturate at ST
    resolve("nt1", 32'h100, BR_BEQ, 1'b0, 32'h140, 1'b1, 32'h140, 1'b1, 32'h104);
    lookup("nt1_post", 32'h100, 1'b0, 32'd0);
    resolve("nt2", 32'h100, BR_BEQ, 1'b0, 32'h140, 1'b0, 32'd0, 1'b0, 32'h104);
    resolve("t1", 32'h100, BR_BEQ, 1'b1, 32'h140, 1'b0, 32'd0, 1'b1, 32'h140);
    resolve("t2", 32'h100, BR_BEQ, 1'b1, 32'h140, 1'b0, 32'd0, 1'b1, 32'h140);
    lookup("t2_post", 32'h100, 1'b1, 32'h140);
    resolve("t3", 32'h100, BR_BEQ, 1'b1, 32'h140, 1'b1, 32'h140, 1'b0, 32'h140);
    resolve("t4", 32'h100, BR_BEQ, 1'b1, 32'h140, 1'b1, 32'h140, 1'b0, 32'h140);
    // target change on a predicted-taken hit
    resolve("tgt", 32'h100, BR_BEQ, 1'b1, 32'h180, 1'b1, 32'h140, 1'b1, 32'h180);
    lookup("tgt_post", 32'h100, 1'b1, 32'h180);
    // ST->WT still taken proves saturation held at ST
    resolve("sat1", 32'h100, BR_BEQ, 1'b0, 32'h180, 1'b1, 32'h180, 1'b1, 32'h104);
    lookup("sat1_post", 32'h100, 1'b1, 32'h180);
    resolve("sat2", 32'h100, BR_BEQ, 1'b0, 32'h180, 1'b1, 32'h180, 1'b1, 32'h104);
    lookup("sat2_post", 32'h100, 1'b0, 32'd0);

    // 4: tag alias on index 0
    resolve("al_a", 32'h100, BR_BNE, 1'b1, 32'h140, 1'b0, 32'd0, 1'b1, 32'h140);
    lookup("al_a_post", 32'h100, 1'b1, 32'h140);
    resolve("al_b", 32'h200, BR_BLT, 1'b1, 32'h240, 1'b0, 32'd0, 1'b1, 32'h240);
    lookup("al_old", 32'h100, 1'b0, 32'd0);
    lookup("al_new", 32'h200, 1'b1, 32'h240);
    resolve("al_nt", 32'h300, BR_BGEU, 1'b0, 32'h340, 1'b0, 32'd0, 1'b0, 32'h304);
    lookup("al_keep", 32'h200, 1'b1, 32'h240);
    lookup("al_miss", 32'h300, 1'b0, 32'd0);
    lookup("other_idx", 32'h104, 1'b0, 32'd0);

    // 5: stalled branch neither trains nor counts
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.PCE         = 32'h408;
      bus.BranchTypeE = BR_BEQ;
      bus.BranchE     = 1'b1;
      bus.BrTargetE   = 32'h500;
      bus.PredTakenE  = 1'b0;
      bus.PredTargetE = 32'd0;
      bus.StallE      = 1'b1;
      #1;
      check("stall_mispred", {31'd0, bus.MispredE}, 32'd0);
      check_counters("stall");
      lookup("stall_lk", 32'h408, 1'b0, 32'd0);
    end
    resolve("unstall", 32'h408, BR_BEQ, 1'b1, 32'h500, 1'b0, 32'd0, 1'b1, 32'h500);
    lookup("unstall_post", 32'h408, 1'b1, 32'h500);

    // 6: reset in the same cycle as a taken BNE aborts it
    @(negedge clk);
    rst_n           = 1'b0;
    bus.PCE         = 32'h60C;
    bus.BranchTypeE = BR_BNE;
    bus.BranchE     = 1'b1;
    bus.BrTargetE   = 32'h700;
    bus.PredTakenE  = 1'b0;
    bus.PredTargetE = 32'd0;
    #1;
    check("rstupd_mispred", {31'd0, bus.MispredE}, 32'd0);
    lookup("rstupd_gate", 32'h200, 1'b0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive_idle();
    exp_br   = 32'd0;
    exp_misp = 32'd0;
    #1;
    lookup("post_rst_new", 32'h60C, 1'b0, 32'd0);
    lookup("post_rst_old", 32'h200, 1'b0, 32'd0);
    lookup("post_rst_old2", 32'h408, 1'b0, 32'd0);
    check_counters("post_rst");
    resolve("post_rst_tr", 32'h60C, BR_BNE, 1'b1, 32'h700, 1'b0, 32'd0, 1'b1, 32'h700);
    lookup("post_rst_tr_post", 32'h60C, 1'b1, 32'h700);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
